// File: rtl/fetch_unit.sv
// fetch_unit -- single-issue instruction fetch front end.
//
// Issues one instruction read per cycle from the current pc and forwards the
// returning word to the IF/ID register. If IF/ID stalls, the word is parked in
// a hold buffer so that memory is not re-read. Redirects that arrive while a
// read is still in flight are deferred: the stale response is drained first,
// and then fetch resumes at the saved target. halt is sticky until reset.
//
// Ports
//   CLK            in   clock, rising edge
//   nRST           in   synchronous reset, active high
//   ihit           in   iload holds the word for imemaddr this cycle
//   iload[31:0]    in   instruction word from memory
//   ifW            in   IF/ID accepts a word this cycle
//   redir          in   redirect request from a later stage
//   redir_addr     in   redirect target (word aligned)
//   halt           in   stop fetching until reset
//   iREN           out  instruction read request
//   imemaddr[31:0] out  fetch address
//   fvalid         out  ifinstr / ifJALjump_addr are deliverable
//   ifinstr        out  instruction to IF/ID, 0 when fvalid=0
//   ifJALjump_addr out  pc+4 of the delivered instruction, 0 when fvalid=0
//   pc             out  current fetch pc
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        ifW,
  input  logic        redir,
  input  logic [31:0] redir_addr,
  input  logic        halt,
  output logic        iREN,
  output logic [31:0] imemaddr,
  output logic        fvalid,
  output logic [31:0] ifinstr,
  output logic [31:0] ifJALjump_addr,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Word parked while IF/ID is stalled, together with its link address.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } hold_t;

  state_t      state, nstate;
  hold_t       hold, nhold;
  logic [31:0] pend, npend;   // redirect target waiting for the drain
  logic [31:0] npc;
  logic [31:0] pc_inc;

  // Natural 32-bit wrap gives the modulo-2^32 increment.
  assign pc_inc = pc + 32'd4;

  // State register
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state <= FETCH;
      pc    <= PC_INIT;
      hold  <= '0;
      pend  <= '0;
    end else begin
      state <= nstate;
      pc    <= npc;
      hold  <= nhold;
      pend  <= npend;
    end
  end

  // Next state and outputs
  always_comb begin
    nstate         = state;
    npc            = pc;
    nhold          = hold;
    npend          = pend;
    iREN           = 1'b0;
    imemaddr       = 32'h0;
    fvalid         = 1'b0;
    ifinstr        = 32'h0;
    ifJALjump_addr = 32'h0;

    if (nRST) begin
      // Reset cycle already requests PC_INIT; the register side is handled
      // in the sequential block.
      iREN     = 1'b1;
      imemaddr = PC_INIT;
    end else begin
      unique case (state)
        FETCH: begin
          iREN     = 1'b1;
          imemaddr = pc;
          if (halt) begin
            nstate = HALT;
          end else if (redir) begin
            if (ihit) begin
              // Returning word is on the wrong path; drop it and retarget now.
              npc = redir_addr;
            end else begin
              // Read still outstanding: its response must be swallowed first.
              npend  = redir_addr;
              nstate = DRAIN;
            end
          end else if (ihit) begin
            fvalid         = 1'b1;
            ifinstr        = iload;
            ifJALjump_addr = pc_inc;
            if (ifW) begin
              npc = pc_inc;
            end else begin
              nhold  = '{instr: iload, npc: pc_inc};
              nstate = HOLD;
            end
          end
        end

        HOLD: begin
          if (halt) begin
            nstate = HALT;
          end else if (redir) begin
            npc    = redir_addr;
            nstate = FETCH;
          end else begin
            fvalid         = 1'b1;
            ifinstr        = hold.instr;
            ifJALjump_addr = hold.npc;
            if (ifW) begin
              npc    = pc_inc;
              nstate = FETCH;
            end
          end
        end

        DRAIN: begin
          // Keep the old address on the bus so the outstanding read completes.
          iREN     = 1'b1;
          imemaddr = pc;
          if (halt) begin
            nstate = HALT;
          end else if (redir) begin
            // Newest redirect wins; if the stale word lands now, go straight
            // to the new target.
            npend = redir_addr;
            if (ihit) begin
              npc    = redir_addr;
              nstate = FETCH;
            end
          end else if (ihit) begin
            npc    = pend;
            nstate = FETCH;
          end
        end

        HALT: begin
          nstate = HALT;
        end

        default: begin
          nstate = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. Inputs change 1ns after the
// rising edge; outputs are checked before the next edge.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] iload;
  logic        ifW;
  logic        redir;
  logic [31:0] redir_addr;
  logic        halt;
  logic        iREN;
  logic [31:0] imemaddr;
  logic        fvalid;
  logic [31:0] ifinstr;
  logic [31:0] ifJALjump_addr;
  logic [31:0] pc;

  int tests = 0;
  int fails = 0;

  fetch_unit #(.PC_INIT(32'h00000000)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .ihit           (ihit),
    .iload          (iload),
    .ifW            (ifW),
    .redir          (redir),
    .redir_addr     (redir_addr),
    .halt           (halt),
    .iREN           (iREN),
    .imemaddr       (imemaddr),
    .fvalid         (fvalid),
    .ifinstr        (ifinstr),
    .ifJALjump_addr (ifJALjump_addr),
    .pc             (pc)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic h, input logic [31:0] w, input logic wr,
                       input logic r, input logic [31:0] ra, input logic hl);
    ihit = h; iload = w; ifW = wr; redir = r; redir_addr = ra; halt = hl;
    #1;
  endtask

  logic [31:0] words [4];

  initial begin
    words[0] = 32'hAAAA0001; words[1] = 32'hBBBB0002;
    words[2] = 32'hCCCC0003; words[3] = 32'hDDDD0004;

    // Reset cycle
    nRST = 1'b1;
    drive(1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_iren", {31'h0, iREN}, 32'h1);
    chk("rst_addr", imemaddr, 32'h0);
    chk("rst_fvalid", {31'h0, fvalid}, 32'h0);
    chk("rst_instr", ifinstr, 32'h0);
    tick();
    nRST = 1'b0;
    #1;
    chk("post_rst_pc", pc, 32'h0);
    chk("post_rst_jal", ifJALjump_addr, 32'h0);

    // Four back-to-back consumed hits
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, words[i], 1'b1, 1'b0, 32'h0, 1'b0);
      chk("stream_fvalid", {31'h0, fvalid}, 32'h1);
      chk("stream_instr", ifinstr, words[i]);
      chk("stream_jal", ifJALjump_addr, 32'(4 * (i + 1)));
      chk("stream_addr", imemaddr, 32'(4 * i));
      tick();
    end
    chk("stream_pc", pc, 32'h10);

    // Redirect with a returning hit: word dropped, retarget immediately
    drive(1'b1, 32'h11111111, 1'b1, 1'b1, 32'h40, 1'b0);
    chk("redir_hit_fvalid", {31'h0, fvalid}, 32'h0);
    tick();
    chk("redir_hit_pc", pc, 32'h40);

    // Stall at 0x40: hold for three cycles, then release
    drive(1'b1, 32'h40404040, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("hold_first_fvalid", {31'h0, fvalid}, 32'h1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h99990000 + i, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("hold_iren", {31'h0, iREN}, 32'h0);
      chk("hold_fvalid", {31'h0, fvalid}, 32'h1);
      chk("hold_instr", ifinstr, 32'h40404040);
      chk("hold_jal", ifJALjump_addr, 32'h44);
      chk("hold_pc", pc, 32'h40);
      tick();
    end
    drive(1'b1, 32'h77777777, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("hold_rel_instr", ifinstr, 32'h40404040);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("hold_rel_pc", pc, 32'h44);
    chk("hold_rel_iren", {31'h0, iREN}, 32'h1);
    chk("hold_rel_addr", imemaddr, 32'h44);

    // Redirect while a read is outstanding -> drain
    drive(1'b1, 32'h0, 1'b1, 1'b1, 32'h40, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0);
    chk("drain_req_fvalid", {31'h0, fvalid}, 32'h0);
    chk("drain_req_addr", imemaddr, 32'h40);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("drain_wait_iren", {31'h0, iREN}, 32'h1);
    chk("drain_wait_addr", imemaddr, 32'h40);
    chk("drain_wait_fvalid", {31'h0, fvalid}, 32'h0);
    tick();
    drive(1'b1, 32'h40404040, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("drain_hit_fvalid", {31'h0, fvalid}, 32'h0);
    chk("drain_hit_instr", ifinstr, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("drain_done_addr", imemaddr, 32'h100);
    chk("drain_done_pc", pc, 32'h100);

    // Second redirect during drain overrides the pending target
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h400, 1'b0);
    tick();
    drive(1'b1, 32'h12345678, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("drain2_fvalid", {31'h0, fvalid}, 32'h0);
    tick();
    chk("drain2_pc", pc, 32'h400);

    // Redirect out of HOLD
    drive(1'b1, 32'h0, 1'b1, 1'b1, 32'h80, 1'b0);
    tick();
    drive(1'b1, 32'h80808080, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b0);
    chk("holdredir_fvalid", {31'h0, fvalid}, 32'h0);
    chk("holdredir_instr", ifinstr, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("holdredir_iren", {31'h0, iREN}, 32'h1);
    chk("holdredir_addr", imemaddr, 32'h200);

    // PC wrap
    drive(1'b1, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0);
    tick();
    drive(1'b1, 32'hFEEDF00D, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_instr", ifinstr, 32'hFEEDF00D);
    chk("wrap_jal", ifJALjump_addr, 32'h0);
    tick();
    chk("wrap_pc", pc, 32'h0);

    // Halt: no delivery, pc frozen, sticky until reset
    drive(1'b1, 32'h0C0C0C0C, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 32'h0D0D0D0D, 1'b1, 1'b1, 32'h500, 1'b1);
    chk("halt_fvalid", {31'h0, fvalid}, 32'h0);
    tick();
    drive(1'b1, 32'h0E0E0E0E, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("halt_pc", pc, 32'h4);
    chk("halt_iren", {31'h0, iREN}, 32'h0);
    chk("halt_fvalid2", {31'h0, fvalid}, 32'h0);
    chk("halt_addr", imemaddr, 32'h0);
    tick();
    chk("halt_sticky_iren", {31'h0, iREN}, 32'h0);
    nRST = 1'b1;
    #1;
    chk("halt_rst_iren", {31'h0, iREN}, 32'h1);
    tick();
    nRST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("halt_rst_pc", pc, 32'h0);
    chk("halt_rst_addr", imemaddr, 32'h0);
    chk("halt_rst_iren2", {31'h0, iREN}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
